// File: rtl/gpio_owner_arb_if.sv
// Signal bundle between the two GPIO owning domains, the pad boundary and gpio_owner_arb.
// The arbiter connects through the slave modport.
interface gpio_owner_arb_if #(
    parameter int unsigned GpioCount = 16
);
    logic [GpioCount-1:0] user_req_i;
    logic [GpioCount-1:0] croc_lock_i;
    logic [GpioCount-1:0] user_gpio_o_i;
    logic [GpioCount-1:0] user_gpio_en_i;
    logic [GpioCount-1:0] croc_gpio_o_i;
    logic [GpioCount-1:0] croc_gpio_en_i;
    logic [GpioCount-1:0] gpio_o;
    logic [GpioCount-1:0] gpio_out_en_o;
    logic [GpioCount-1:0] user_grant_o;
    logic                 handover_o;

    modport master (
        output user_req_i, croc_lock_i, user_gpio_o_i, user_gpio_en_i,
        output croc_gpio_o_i, croc_gpio_en_i,
        input  gpio_o, gpio_out_en_o, user_grant_o, handover_o
    );

    modport slave (
        input  user_req_i, croc_lock_i, user_gpio_o_i, user_gpio_en_i,
        input  croc_gpio_o_i, croc_gpio_en_i,
        output gpio_o, gpio_out_en_o, user_grant_o, handover_o
    );
endinterface

// File: rtl/gpio_owner_arb.sv
// Per-pin run-time GPIO ownership arbiter between the user and croc domains.
// Every handover passes through an undriven guard interval; pad outputs are registered.
module gpio_owner_arb #(
    parameter int unsigned GpioCount   = 16,
    parameter int unsigned GuardCycles = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    gpio_owner_arb_if.slave    bus
);
    typedef enum logic [1:0] {StCroc, StG2u, StUser, StG2c} state_e;

    localparam logic [3:0] CntLoad = 4'(GuardCycles - 1);

    state_e               state_q [GpioCount];
    state_e               state_d [GpioCount];
    logic [3:0]           cnt_q   [GpioCount];
    logic [3:0]           cnt_d   [GpioCount];
    logic [GpioCount-1:0] gpio_d, gpio_q;
    logic [GpioCount-1:0] en_d, en_q;
    logic [GpioCount-1:0] grant;
    logic                 done;
    logic                 done_q;
    logic                 handover_q;

    always_comb begin
        done   = 1'b0;
        gpio_d = '0;
        en_d   = '0;
        grant  = '0;
        for (int i = 0; i < int'(GpioCount); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            grant[i]   = (state_q[i] == StUser);
            unique case (state_q[i])
                StCroc: begin
                    gpio_d[i] = bus.croc_gpio_o_i[i];
                    en_d[i]   = bus.croc_gpio_en_i[i];
                    if (bus.user_req_i[i] && !bus.croc_lock_i[i]) begin
                        state_d[i] = StG2u;
                        cnt_d[i]   = CntLoad;
                    end
                end
                StG2u: begin
                    if (cnt_q[i] == 4'd0) begin
                        state_d[i] = StUser;
                        done       = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 4'd1;
                    end
                end
                StUser: begin
                    gpio_d[i] = bus.user_gpio_o_i[i];
                    en_d[i]   = bus.user_gpio_en_i[i];
                    if (!bus.user_req_i[i]) begin
                        state_d[i] = StG2c;
                        cnt_d[i]   = CntLoad;
                    end
                end
                StG2c: begin
                    if (cnt_q[i] == 4'd0) begin
                        state_d[i] = StCroc;
                        done       = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(GpioCount); i++) begin
                state_q[i] <= StCroc;
                cnt_q[i]   <= 4'd0;
            end
        end else begin
            for (int i = 0; i < int'(GpioCount); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Completion is delayed one extra stage so the pulse lines up with the new owner's values
    // first appearing on the pads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gpio_q     <= '0;
            en_q       <= '0;
            done_q     <= 1'b0;
            handover_q <= 1'b0;
        end else begin
            gpio_q     <= gpio_d;
            en_q       <= en_d;
            done_q     <= done;
            handover_q <= done_q;
        end
    end

    assign bus.gpio_o        = gpio_q;
    assign bus.gpio_out_en_o = en_q;
    assign bus.user_grant_o  = grant;
    assign bus.handover_o    = handover_q;
endmodule

// File: doc/gpio_owner_arb.md
# gpio_owner_arb

Per-pin GPIO ownership arbiter between the user domain and the croc domain. It replaces the static pin split at the SoC GPIO boundary with a run-time handover. Each pin has a small state machine that moves ownership between the two domains. During every handover the pin passes through a guard interval in which neither domain drives it. The final pad-facing data and output-enable are registered.

## Interface
- `GpioCount`, default 16: number of GPIO pins arbitrated.
- `GuardCycles`, default 2: length of the undriven guard interval in cycles. Legal range is 1..15.

Ports:
- `clk_i`  in  1  system clock. All state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `user_req_i`  in  GpioCount  user domain requests ownership of pin i. Level-sensitive.
- `croc_lock_i`  in  GpioCount  croc domain refuses handover of pin i to the user domain.
- `user_gpio_o_i`  in  GpioCount  user domain output data.
- `user_gpio_en_i`  in  GpioCount  user domain output enable.
- `croc_gpio_o_i`  in  GpioCount  croc domain output data.
- `croc_gpio_en_i`  in  GpioCount  croc domain output enable.
- `gpio_o`  out  GpioCount  registered pad output data.
- `gpio_out_en_o`  out  GpioCount  registered pad output enable. 1 means drive.
- `user_grant_o`  out  GpioCount  pin i is in state USER.
- `handover_o`  out  1  one-cycle pulse when any pin completes a handover in either direction.

## Operation
- Each pin has an independent FSM with four states: CROC (the reset and default state), G2U, USER and G2C. Each pin also has a 4-bit guard counter `cnt`.
- Transitions are evaluated on every clock edge:
  - CROC → G2U when `user_req_i[i]`=1 and `croc_lock_i[i]`=0. Load `cnt` = GuardCycles-1.
  - G2U: if `cnt`==0, go to USER; otherwise decrement `cnt`. The `user_req_i` and `croc_lock_i` inputs are ignored in this state. A started guard always completes.
  - USER → G2C when `user_req_i[i]`=0. Load `cnt` = GuardCycles-1. `croc_lock_i` has no effect in USER.
  - G2C: if `cnt`==0, go to CROC; otherwise decrement `cnt`. Inputs are ignored.
- Requests are re-evaluated in CROC and USER only. If a request is withdrawn during G2U, the pin still reaches USER and then leaves on the next edge, entering G2C.
- If a request arrives while lock=1 in CROC, the pin stays in CROC and no state is kept about the request. The handover starts on the first edge where lock=0 and req=1.
- Combinational mux, sampled into the output registers on each edge:
  - CROC selects the croc data and enable.
  - USER selects the user data and enable.
  - G2U and G2C force data=0 and enable=0.
- `user_grant_o[i]` = (state==USER), decoded directly from the state register.
- `handover_o` is registered. It is set for one cycle after any edge on which any pin moves G2U→USER or G2C→CROC. Simultaneous completions on several pins still produce a single pulse.

## Timing
- Reset values while `rst_i`=1, taking effect asynchronously:
  - every pin in CROC with `cnt`=0;
  - `gpio_o`=0, `gpio_out_en_o`=0;
  - `user_grant_o`=0, `handover_o`=0.
- First edge after reset release: the output registers load the croc values.
- Handover latency with the request sampled at edge E0:
  - The state is G2U for GuardCycles cycles, after edges E0 through E0+GuardCycles-1.
  - The state is USER after edge E0+GuardCycles. `user_grant_o` rises in that same cycle.
  - The pads show user values after edge E0+GuardCycles+1.
  - The pads show enable=0 from edge E0+1 until user values appear: GuardCycles consecutive cycles.
  - `handover_o` is high in the cycle after edge E0+GuardCycles+1.
- Return to CROC is symmetric, measured from the edge on which `user_req_i`=0 is sampled in USER.
- Data path outside handovers: one cycle latency from a domain's inputs to the pads.
- Reset asserted mid-handover: the pin returns to CROC immediately. No guard is applied after release.

## Test plan
- Reset and default, with GpioCount=16 and GuardCycles=2: croc data=0xA5A5 and croc enable=0xFFFF, no requests. Required response: zeros during reset; `gpio_o`=0xA5A5 and `gpio_out_en_o`=0xFFFF one edge after release; `user_grant_o`=0.
- Single handover: raise `user_req_i[5]` with user data[5]=1 and user enable[5]=1.
  - Pin 5 enable is 0 for exactly 2 cycles, then pin 5 is driven 1.
  - `user_grant_o`=0x0020.
  - One `handover_o` pulse.
  - All other pins are unchanged throughout.
- Lock: hold `croc_lock_i[3]`=1 with `user_req_i[3]`=1 for 10 cycles. Required response: pin 3 stays croc-driven with no guard. After lock drops, grant appears GuardCycles+1 edges later.
- Withdraw during guard: drop `user_req_i[0]` on the cycle after the request was sampled.
  - The pin still reaches USER for 1 cycle.
  - It then passes through G2C for 2 cycles and returns to CROC.
  - `handover_o` pulses twice.
  - Pin 0 is never driven by both domains.
- Simultaneous: raise the requests for pins 0, 1 and 2 on the same edge. Required response: grants rise together and `handover_o` pulses once.
- Reset mid-guard: assert `rst_i` during G2U. Required response: outputs go to 0 immediately. After release the pin is in CROC and `user_grant_o`=0.
